// File: rtl/mem_responder.sv
// mem_responder: word RAM target for the multicycle core with wait states, byte lanes and error responses
module mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT_RD    = 2,
  parameter int WAIT_WR    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  if (WAIT_RD < 0 || WAIT_RD > 15 || WAIT_WR < 0 || WAIT_WR > 15) begin : g_wait_range
    $error("mem_responder: WAIT_RD and WAIT_WR must be within 0..15");
  end
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] RD4 = 4'(WAIT_RD);
  localparam logic [3:0] WR4 = 4'(WAIT_WR);
  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_ld, be_q, be_d;
  logic we_q, we_d, err_q, err_d, handshake, mem_we;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  assign req_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  // latch the request at handshake, sequence IDLE->WAIT->RESP, and form the response one edge after RESP
  always_comb begin
    handshake   = req_valid && state_q == IDLE;
    cnt_ld      = req_we ? WR4 : RD4;
    we_d        = handshake ? req_we : we_q;
    be_d        = handshake ? req_be : be_q;
    wdata_d     = handshake ? req_wdata : wdata_q;
    idx_d       = handshake ? req_addr[DEPTH_LOG2+1:2] : idx_q;
    err_d       = handshake ? (req_addr[1:0] != 2'd0 || req_addr[31:DEPTH_LOG2+2] != '0) : err_q;
    cnt_d       = handshake ? cnt_ld : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
    state_d     = state_q == RESP ? IDLE :
                  state_q == WAIT ? (cnt_q == 4'd1 ? RESP : WAIT) :
                  handshake ? (cnt_ld != 4'd0 ? WAIT : RESP) : IDLE;
    mem_we      = state_q != RESP && state_d == RESP && we_d && !err_d;
    rsp_valid_d = state_q == RESP;
    rsp_rdata_d = state_q == RESP ? ((we_q || err_q) ? 32'd0 : mem[idx_q]) : rsp_rdata_q;
    rsp_err_d   = state_q == RESP ? err_q : rsp_err_q;
  end
  // control and response registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
  // store lanes commit on the edge that enters RESP so a following load sees them
  always_ff @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (be_d[i]) mem[idx_d][8*i +: 8] <= wdata_d[8*i +: 8];
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of latency, byte lanes, errors, zero-wait handshake and reset abort
module tb_mem_responder;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_we = 0, req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata;
  logic [3:0] req_be = 0;
  logic v0 = 0, we0 = 0, rdy0, rv0, re0, busy0;
  logic [31:0] a0 = 0, wd0 = 0, rd0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mem_responder #(.DEPTH_LOG2(10), .WAIT_RD(2), .WAIT_WR(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy));
  mem_responder #(.DEPTH_LOG2(10), .WAIT_RD(0), .WAIT_WR(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_addr(a0), .req_wdata(wd0), .req_be(4'hF), .rsp_valid(rv0),
    .rsp_rdata(rd0), .rsp_err(re0), .busy(busy0));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic xfer(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int lat, input logic [31:0] rdata, input logic err);
    int k;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk);
    #1 req_valid = 0;
    k = 0;
    for (int c = 1; c <= 20 && k == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) k = c;
    end
    chk({tag, ".lat"}, 32'(k), 32'(lat));
    chk({tag, ".rdata"}, rsp_rdata, rdata);
    chk({tag, ".err"}, 32'(rsp_err), 32'(err));
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
  endtask
  initial begin
    #12;
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.valid", 32'(rsp_valid), 32'd0);
    @(negedge clk) rst = 0;
    xfer("wr10", 1, 32'h10, 32'hDEADBEEF, 4'hF, 3, 32'h0, 0);
    xfer("rd10", 0, 32'h10, 32'h0, 4'hF, 4, 32'hDEADBEEF, 0);
    xfer("wr20a", 1, 32'h20, 32'h11223344, 4'hF, 3, 32'h0, 0);
    xfer("wr20b", 1, 32'h20, 32'hAABBCCDD, 4'b0101, 3, 32'h0, 0);
    xfer("rd20", 0, 32'h20, 32'h0, 4'h0, 4, 32'h11BB33DD, 0);
    xfer("wr0", 1, 32'h0, 32'h5A5A5A5A, 4'hF, 3, 32'h0, 0);
    xfer("rd6", 0, 32'h6, 32'h0, 4'hF, 4, 32'h0, 1);
    xfer("wr1000", 1, 32'h1000, 32'hFFFFFFFF, 4'hF, 3, 32'h0, 1);
    xfer("rd0", 0, 32'h0, 32'h0, 4'hF, 4, 32'h5A5A5A5A, 0);
    xfer("wr40", 1, 32'h40, 32'h01234567, 4'hF, 3, 32'h0, 0);
    xfer("rd40a", 0, 32'h40, 32'h0, 4'hF, 4, 32'h01234567, 0);
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk);
    #1 req_valid = 0;
    chk("abort.busy_wait", 32'(busy), 32'd1);
    rst = 1;
    #1;
    chk("abort.ready", 32'(req_ready), 32'd1);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.valid", 32'(rsp_valid), 32'd0);
    chk("abort.rdata", rsp_rdata, 32'h0);
    chk("abort.err", 32'(rsp_err), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort.novalid", 32'(rsp_valid), 32'd0);
    end
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort.novalid2", 32'(rsp_valid), 32'd0);
    end
    xfer("rd40b", 0, 32'h40, 32'h0, 4'hF, 4, 32'h01234567, 0);
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c <= 8; c++) begin
        @(negedge clk);
        chk($sformatf("z%0d.ready%0d", p, c), 32'(rdy0), 32'(c % 2 == 0));
        chk($sformatf("z%0d.valid%0d", p, c), 32'(rv0), 32'(c >= 2 && c % 2 == 0));
        if (c >= 2 && c % 2 == 0)
          chk($sformatf("z%0d.rdata%0d", p, c), rd0, p == 0 ? 32'h0 : 32'hA0A0_0000 + 32'(c / 2 - 1));
        if (c % 2 == 0 && c < 8) begin
          v0 = 1; we0 = p == 0; a0 = 32'h100 + 32'(4 * (c / 2)); wd0 = 32'hA0A0_0000 + 32'(c / 2);
        end
        if (c == 7) v0 = 0;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
